// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver for host commands. Every good byte is
// exposed on data_o with a one-cycle rx_done_o pulse. A CMD_START byte
// received while idle fires a one-cycle start_o pulse to the acquisition
// top and holds busy_o until that top reports end-of-sequence on eos_i.
module uart_cmd_rx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  CMD_START    = 8'h53
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       eos_i,
  output logic       start_o,
  output logic       busy_o,
  output logic [7:0] data_o,
  output logic       rx_done_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_PT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_PT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [CW-1:0]   baudCnt_q;
  logic [2:0]      bitIdx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            rxDone_q;
  logic            frameErr_q;
  logic            rxMeta_q;
  logic            rxSync_q;
  logic            start_q;
  logic            busy_q;
  logic            start_d;
  logic            busy_d;

  // Bring the asynchronous line into the clock domain; idle-high after reset
  // so a reset never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
    end
  end

  // Receive FSM: find start edge, confirm it mid-bit, then sample each data
  // bit and the stop bit one full bit period apart, LSB first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      rxDone_q   <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      rxDone_q   <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxSync_q) begin
            state_q   <= START;
            baudCnt_q <= '0;
          end
        end
        START: begin
          if (baudCnt_q == HALF_PT) begin
            if (!rxSync_q) begin
              state_q   <= DATA;
              baudCnt_q <= '0;
              bitIdx_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baudCnt_q == LAST_PT) begin
            baudCnt_q         <= '0;
            shift_q[bitIdx_q] <= rxSync_q;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bitIdx_q <= bitIdx_q + 1'b1;
            end
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end
        STOP: begin
          if (baudCnt_q == LAST_PT) begin
            baudCnt_q <= '0;
            if (rxSync_q) begin
              data_q   <= shift_q;
              rxDone_q <= 1'b1;
            end else begin
              frameErr_q <= 1'b1;
            end
            state_q <= IDLE;
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Command decode: busy is looked at before any eos clear, so a command that
  // lands together with eos while busy is dropped and busy simply falls.
  always_comb begin
    start_d = rxDone_q && (data_q == CMD_START) && !busy_q;
    busy_d  = busy_q;
    if (busy_q && eos_i) begin
      busy_d = 1'b0;
    end else if (start_d) begin
      busy_d = 1'b1;
    end
  end

  // Register the command outputs so start_o and busy_o rise together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign start_o     = start_q;
  assign busy_o      = busy_q;
  assign data_o      = data_q;
  assign rx_done_o   = rxDone_q;
  assign frame_err_o = frameErr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: drives 8N1 frames into uart_cmd_rx and compares every
// output pulse against events predicted by a byte-level reference model.
module tb_uart_cmd_rx;

  localparam int         CPB = 16;
  localparam logic [7:0] CMD = 8'h53;
  localparam int EV_BYTE  = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_START = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } event_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic       eos_i;
  logic       start_o;
  logic       busy_o;
  logic [7:0] data_o;
  logic       rx_done_o;
  logic       frame_err_o;

  logic       eosManual  = 1'b0;
  logic       eosOnDone  = 1'b0;
  logic       modelBusy  = 1'b0;
  logic [7:0] lastData   = 8'h00;
  event_t     expQ[$];
  int         checks     = 0;
  int         errors     = 0;
  int         cycle      = 0;
  int         lastDoneCycle = -10;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .CMD_START(CMD)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .eos_i      (eos_i),
    .start_o    (start_o),
    .busy_o     (busy_o),
    .data_o     (data_o),
    .rx_done_o  (rx_done_o),
    .frame_err_o(frame_err_o)
  );

  // 100 MHz clock
  always #5 clk_i = ~clk_i;

  // eos comes from an explicit pulse or, in coincidence mode, tracks rx_done_o
  assign eos_i = eosManual | (eosOnDone & rx_done_o);

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic pushEv(input int kind, input logic [7:0] data);
    event_t ev;
    ev.kind = kind;
    ev.data = data;
    expQ.push_back(ev);
  endtask

  // Drive one frame; abortAt >= 0 resets the DUT halfway through that data bit
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                               input int abortAt, input int gap);
    if (abortAt < 0) begin
      if (stopBit) begin
        pushEv(EV_BYTE, b);
        lastData = b;
        if (modelBusy && eosOnDone) begin
          modelBusy = 1'b0;
        end else if (b == CMD && !modelBusy) begin
          pushEv(EV_START, b);
          modelBusy = 1'b1;
        end
      end else begin
        pushEv(EV_FERR, lastData);
      end
    end
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      if (i == abortAt) begin
        repeat (CPB / 2) @(negedge clk_i);
        rst_i = 1'b1;
        rx_i  = 1'b1;
        @(negedge clk_i);
        modelBusy = 1'b0;
        lastData  = 8'h00;
        checkOutput("abort data_o", data_o, 0);
        checkOutput("abort busy_o", busy_o, 0);
        checkOutput("abort start_o", start_o, 0);
        checkOutput("abort rx_done_o", rx_done_o, 0);
        checkOutput("abort frame_err_o", frame_err_o, 0);
        rst_i = 1'b0;
        repeat (CPB * 12) @(negedge clk_i);
        return;
      end
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = stopBit;
    repeat (CPB) @(negedge clk_i);
    rx_i = 1'b1;
    if (!stopBit) repeat (CPB + 4) @(negedge clk_i);
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic pulseEos();
    eosManual = 1'b1;
    @(negedge clk_i);
    eosManual = 1'b0;
    modelBusy = 1'b0;
    @(negedge clk_i);
  endtask

  // Monitor: every output pulse must match the next predicted event
  always @(negedge clk_i) begin
    event_t ev;
    cycle++;
    if (rx_done_o) begin
      lastDoneCycle = cycle;
      if (expQ.size() == 0) checkOutput("unexpected rx_done_o", 1, 0);
      else begin
        ev = expQ.pop_front();
        checkOutput("rx_done kind", EV_BYTE, ev.kind);
        checkOutput("rx_done data_o", data_o, ev.data);
      end
    end
    if (frame_err_o) begin
      if (expQ.size() == 0) checkOutput("unexpected frame_err_o", 1, 0);
      else begin
        ev = expQ.pop_front();
        checkOutput("frame_err kind", EV_FERR, ev.kind);
        checkOutput("frame_err data_o held", data_o, ev.data);
      end
    end
    if (start_o) begin
      if (expQ.size() == 0) checkOutput("unexpected start_o", 1, 0);
      else begin
        ev = expQ.pop_front();
        checkOutput("start kind", EV_START, ev.kind);
        checkOutput("start latency", cycle - lastDoneCycle, 1);
        checkOutput("busy_o with start_o", busy_o, 1);
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       sb;
    int         drain;
    rst_i = 1'b1;
    rx_i  = 1'b1;
    repeat (4) @(negedge clk_i);
    checkOutput("reset start_o", start_o, 0);
    checkOutput("reset busy_o", busy_o, 0);
    checkOutput("reset data_o", data_o, 0);
    checkOutput("reset rx_done_o", rx_done_o, 0);
    checkOutput("reset frame_err_o", frame_err_o, 0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);

    $display("[TB] start command and eos");
    applyStimulus(CMD, 1'b1, -1, 4);
    checkOutput("busy after start", busy_o, modelBusy);
    eosManual = 1'b1;
    @(negedge clk_i);
    eosManual = 1'b0;
    modelBusy = 1'b0;
    checkOutput("busy cleared after eos", busy_o, 0);
    repeat (3) @(negedge clk_i);

    $display("[TB] non-command byte");
    applyStimulus(8'h41, 1'b1, -1, 4);
    checkOutput("busy after 0x41", busy_o, 0);
    checkOutput("data_o 0x41", data_o, 8'h41);

    $display("[TB] framing error");
    applyStimulus(CMD, 1'b0, -1, 4);
    checkOutput("data_o held after ferr", data_o, 8'h41);
    checkOutput("busy after ferr", busy_o, 0);

    $display("[TB] start glitch");
    rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (CPB * 3) @(negedge clk_i);
    checkOutput("data_o after glitch", data_o, 8'h41);

    $display("[TB] command while busy, command with eos");
    applyStimulus(CMD, 1'b1, -1, 4);
    checkOutput("busy set", busy_o, 1);
    applyStimulus(CMD, 1'b1, -1, 4);
    checkOutput("busy stays", busy_o, 1);
    eosOnDone = 1'b1;
    applyStimulus(CMD, 1'b1, -1, 4);
    eosOnDone = 1'b0;
    checkOutput("busy after coincident eos", busy_o, modelBusy);

    $display("[TB] reset mid-frame");
    applyStimulus(CMD, 1'b1, -1, 4);
    applyStimulus(8'h3C, 1'b1, 3, 0);
    applyStimulus(8'hA5, 1'b1, -1, 4);
    checkOutput("data_o after reset", data_o, 8'hA5);
    checkOutput("busy after reset", busy_o, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      b  = ($urandom_range(0, 3) == 0) ? CMD : 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      applyStimulus(b, sb, -1, $urandom_range(0, 12));
      checkOutput("random busy_o", busy_o, modelBusy);
      checkOutput("random data_o", data_o, lastData);
      if ($urandom_range(0, 2) == 0) pulseEos();
    end

    drain = 0;
    while (expQ.size() > 0 && drain < 2000) begin
      @(negedge clk_i);
      drain++;
    end
    checkOutput("events outstanding", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
